// File: rtl/bf_uart_pkg.sv
// bf_uart_pkg: shared types and constants for the UART transmit path.
//   tx_state_t   - transmitter FSM states
//   clks_per_bit - rounded clk cycles per serial bit
//   FRAME_BITS   - bits per 8N1 frame (start + 8 data + stop)
package bf_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  // Nearest-integer divide so the bit period error is at most half a clock.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/bf_uart_tx_if.sv
// bf_uart_tx_if: the core's output-byte write path.
//   wr_stb  - output-write strobe, a level that may stay high for many cycles
//   wr_data - byte to send, stable from the wr_stb rise for 3 clk edges
// Semantics: each low-to-high transition of wr_stb offers exactly one byte.
// There is no ready back-pressure; a byte offered while the buffer is full
// is dropped and flagged by the consumer.
interface bf_uart_tx_if;
  logic       wr_stb;
  logic [7:0] wr_data;

  modport master (output wr_stb, output wr_data);
  modport slave  (input  wr_stb, input  wr_data);
endinterface

// File: rtl/bf_byte_fifo.sv
// bf_byte_fifo: small byte FIFO with power-of-two depth.
//   clk, rst  - clock, asynchronous active-high reset
//   push, din - write request and data
//   pop       - read request; dout shows the head entry combinationally
//   count     - entries held; full/empty derived from it
//   drop      - push refused because full with no simultaneous pop
module bf_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full  = (cnt == DEPTH_C);
  assign empty = (cnt == '0);
  assign count = cnt;
  assign dout  = mem[rptr];

  // A pop on the same edge frees a slot, so a push into a full FIFO is
  // still accepted then.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/bf_uart_tx.sv
// bf_uart_tx: captures one byte per rising edge of the core's output-write
// strobe, buffers it, and serialises it as an 8N1 frame on uart_tx.
//   clk, rst   - board clock, asynchronous active-high reset
//   wr         - strobe/data write path (slave side)
//   uart_tx    - serial line, idle high
//   busy       - frame in progress or bytes buffered
//   fifo_full  - buffer holds FIFO_DEPTH bytes
//   fifo_count - bytes buffered, not counting the frame on the wire
//   overflow   - sticky: a byte was dropped because the buffer was full
//   state_dbg  - current transmitter state
module bf_uart_tx
  import bf_uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  bf_uart_tx_if.slave                   wr,
  output logic                          uart_tx,
  output logic                          busy,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output tx_state_t                     state_dbg
);

  localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
  localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  // Strobe synchroniser and rising-edge detect. The strobe comes from a
  // slow divided-clock domain and can be held for many cycles, so only its
  // rise produces a push.
  logic s1, s2, s3;
  logic push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= wr.wr_stb;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign push = s2 & ~s3;

  // Byte buffer. wr_data is still stable on the push edge, so it is written
  // directly without its own synchroniser.
  logic [7:0] fifo_dout;
  logic       fifo_empty;
  logic       fifo_drop;
  logic       pop;

  bf_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (wr.wr_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  // Transmitter state.
  tx_state_t     state, state_n;
  logic [BW-1:0] baud_cnt, baud_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    shreg, sh_n;
  logic          tx_q, tx_n;
  logic          baud_done;

  assign baud_done = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shreg    <= sh_n;
      tx_q     <= tx_n;
    end
  end

  // The line value is registered together with the state change, so each
  // transition loads the level of the bit that starts on that edge.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    sh_n    = shreg;
    tx_n    = tx_q;
    pop     = 1'b0;

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_n    = fifo_dout;
          tx_n    = 1'b0;
          baud_n  = '0;
          state_n = START;
        end
      end

      START: begin
        if (baud_done) begin
          baud_n  = '0;
          bit_n   = '0;
          tx_n    = shreg[0];
          state_n = DATA;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end

      DATA: begin
        if (baud_done) begin
          baud_n = '0;
          if (bit_cnt == BIT_LAST) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            bit_n = bit_cnt + 1'b1;
            sh_n  = {1'b0, shreg[7:1]};
            tx_n  = shreg[1];
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end

      STOP: begin
        if (baud_done) begin
          baud_n = '0;
          // Chain straight into the next start bit so queued bytes leave
          // with no idle gap between frames.
          if (!fifo_empty) begin
            pop     = 1'b1;
            sh_n    = fifo_dout;
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            overflow <= 1'b0;
    else if (fifo_drop) overflow <= 1'b1;
  end

  assign uart_tx   = tx_q;
  assign busy      = (state != IDLE) | (fifo_count != '0);
  assign state_dbg = state;

endmodule

// File: doc/bf_uart_tx.md
Name: bf_uart_tx

Overview:
Downstream consumer of the core's output-byte path. It captures each byte the core emits on an output instruction, qualified by the multi-cycle output-write strobe. Captured bytes are buffered in a small FIFO and serialised as 8N1 UART frames on the board pin. This decouples the slow, divided-clock core from the baud rate, and guarantees exactly one frame per output instruction regardless of strobe length.

Parameters:
CLK_HZ, 50_000_000, frequency of clk in Hz
BAUD, 115200, line rate
FIFO_DEPTH, 16, byte slots; power of two, >= 2
CLKS_PER_BIT, (CLK_HZ + BAUD/2)/BAUD, derived localparam, >= 2

Ports:
clk  in  1  base board clock; the only clock
rst  in  1  asynchronous, active-high reset
wr_stb  in  1  output-write strobe; level, may stay high for many clk cycles
wr_data  in  8  byte to send; stable from wr_stb rise until 3 clk edges later
uart_tx  out  1  serial line, idle high
busy  out  1  frame in progress or FIFO non-empty
fifo_full  out  1  FIFO holds FIFO_DEPTH bytes
fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes buffered, excludes frame in flight
overflow  out  1  sticky: a byte was dropped because the FIFO was full

Behaviour:
- Reset values (async, rst=1): uart_tx=1, busy=0, fifo_full=0, fifo_count=0, overflow=0. FIFO pointers=0, state=IDLE, baud/bit counters=0.
- Reset mid-frame: the line returns high immediately and the frame is abandoned. Buffered bytes are discarded.
- Strobe capture: wr_stb passes a 2-flop synchroniser (s1, s2) and then a delay flop s3.
- push = s2 & ~s3: exactly one push per wr_stb rising edge, however long the strobe is held. A strobe that is high coming out of reset pushes once.
- Push writes wr_data (sampled on the push edge) at wptr, then wptr+1 mod FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: if FIFO non-empty, pop: shreg <= mem[rptr], rptr+1 mod depth, uart_tx <= 0, go to START, baud counter cleared.
- START: hold 0 for CLKS_PER_BIT clocks, then output shreg[0] and go to DATA with bit index 0.
- DATA: each bit is held CLKS_PER_BIT clocks, LSB first. After bit 7 completes, output 1 and go to STOP.
- STOP: hold 1 for CLKS_PER_BIT clocks. Then:
  - FIFO non-empty: pop and go directly to START, so back-to-back frames have no idle gap.
  - FIFO empty: go to IDLE.
- Frame length: exactly 10*CLKS_PER_BIT clocks.
- Latency: with the FSM in IDLE and the FIFO empty, the edge sampling wr_stb high is edge 1.
  - s2 goes high at edge 2.
  - push occurs at edge 3.
  - pop occurs at edge 4; uart_tx is low after edge 4.
- Push and pop on the same edge: both take effect, and fifo_count is unchanged. This is allowed even when the FIFO is full, because the pop frees a slot and the push is accepted.
- Push while full without a simultaneous pop: the byte is dropped, pointers and count are unchanged, and overflow is set to 1. overflow is cleared only by rst.
- Pop is never issued when the FIFO is empty.
- fifo_full = (fifo_count == FIFO_DEPTH).
- busy = (state != IDLE) | (fifo_count != 0).
- All outputs are registered or derived from registers only; no combinational path from wr_stb or wr_data to any output.

Decomposition:
- Package bf_uart_pkg:
  - tx_state_t enum {IDLE, START, DATA, STOP}.
  - Function clks_per_bit(CLK_HZ, BAUD).
  - Constant for the frame length of 10 bits.
- Sub-module bf_byte_fifo (parameter DEPTH):
  - Ports: clk, rst, push, din, pop, dout, count, full, empty.
  - Handles the simultaneous push/pop and full-drop rules above, and reports the drop via a drop output.
- The top block holds the synchroniser, edge detect, FSM, baud counter, shift register and sticky flag.

Test Plan:
1. CLK_HZ=1_000_000, BAUD=100_000 (10 clk/bit); wr_data=0x41, 1-cycle strobe -> uart_tx low after edge 4. Line then reads 0,1,0,0,0,0,0,1,0,1, each 10 clocks. busy falls 100 clocks after the frame starts.
2. wr_data=0x55 with wr_stb held high for 500 clocks -> exactly one frame. fifo_count never exceeds 1, and no second frame follows.
3. Strobes 0x01, 0x02, 0x03 spaced 6 clocks apart -> three contiguous frames, 300 clocks total, no idle-high gap between stop and start. fifo_count peaks at 2.
4. FIFO_DEPTH=4; six strobes 0x10..0x15 spaced 8 clocks, all before the first frame ends -> 0x10..0x14 transmitted, 0x15 dropped. overflow=1 and stays 1 until rst; fifo_full=1 after the 5th push.
5. rst pulsed during bit 3 of a 0xA5 frame with 2 bytes queued -> uart_tx=1 within the reset cycle (asynchronous). After release: busy=0, fifo_count=0, overflow=0, no further frames.
6. FIFO full (DEPTH=4) and a push landing on the same edge as the STOP->START pop -> byte accepted, overflow stays 0, fifo_count stays 4, and all bytes are eventually sent in order.
